online_softmax_stat: RTL

- Producer side of the flash-attention output-rescale path: tracks per-row running max m and running exp-sum l across score tiles.
- Ingests one score tile column-by-column (TIL rows in parallel) and buffers it.
- Replays the buffered tile through per-row exp pipes and computes m_new and l_new.
- Presents old/new {l, m} to the coefficient updater with O_ENA held until that updater reports valid, then commits new→old.

---
 rtl/online_softmax_stat.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/online_softmax_stat.sv
// Per-row running max / exp-sum tracker for tiled softmax: buffers one score tile,
// replays it through exp pipes and hands old/new {l, m} to the rescale stage.
module online_softmax_stat #(
    parameter int unsigned D_W     = 16,
    parameter int unsigned TIL     = 16,
    parameter int unsigned COLS    = 16,
    parameter int unsigned FRAC    = 8,
    parameter int unsigned EXP_LAT = 2
) (
    input  logic           I_CLK,
    input  logic           I_RST,
    input  logic           I_START,
    input  logic           I_S_VLD,
    input  logic [D_W-1:0] I_S_COL   [0:TIL-1],
    output logic           O_S_RDY,
    output logic           O_ENA,
    output logic [D_W-1:0] O_LI_OLD  [0:TIL-1],
    output logic [D_W-1:0] O_MI_OLD  [0:TIL-1],
    output logic [D_W-1:0] O_LI_NEW  [0:TIL-1],
    output logic [D_W-1:0] O_MI_NEW  [0:TIL-1],
    input  logic           I_UPD_VLD,
    output logic           O_BUSY
);

    localparam int unsigned CW = $clog2(COLS + 1);
    localparam int unsigned BW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned AW = D_W + 1;
    localparam int unsigned SW = D_W + $clog2(COLS) + 1;
    localparam int unsigned PW = 2 * D_W;
    localparam logic [D_W-1:0] NEG_INF = {1'b1, {(D_W - 1){1'b0}}};
    localparam logic [D_W-1:0] L_MAX   = {1'b0, {(D_W - 1){1'b1}}};
    localparam logic [D_W-1:0] ONE     = D_W'(1 << FRAC);
    localparam int signed LOG2E        = 94548 >>> (16 - FRAC);
    localparam int signed EXP_FLOOR    = -(8 << FRAC);

    typedef enum logic [2:0] {StIdle, StLoad, StSum, StDrain, StScale, StOut} state_e;

    state_e            state_q, state_d;
    logic              col_acc, last_col;
    logic [BW-1:0]     col_cnt_q, rd_idx;
    logic [CW-1:0]     iss_cnt_q;
    logic              first_q;
    logic [D_W-1:0]    tile_q    [0:COLS-1][0:TIL-1];
    logic [D_W-1:0]    run_max_q [0:TIL-1];
    logic [D_W-1:0]    l_old_q   [0:TIL-1];
    logic [D_W-1:0]    m_old_q   [0:TIL-1];
    logic [D_W-1:0]    l_new_q   [0:TIL-1];
    logic [D_W-1:0]    m_new_q   [0:TIL-1];
    logic [D_W-1:0]    alpha_q   [0:TIL-1];
    logic [SW-1:0]     sum_q     [0:TIL-1];
    logic [AW-1:0]     arg_q     [0:TIL-1];
    logic [D_W-1:0]    exp_q     [0:EXP_LAT-1][0:TIL-1];
    logic              a_vld_q, a_item0_q, a_last_q;
    logic [EXP_LAT-1:0] e_vld_q, e_item0_q, e_last_q;
    logic              out_vld, out_item0, out_last;
    logic signed [PW-1:0] prod  [0:TIL-1];
    logic signed [PW-1:0] total [0:TIL-1];
    logic [D_W-1:0]    l_sat     [0:TIL-1];

    function automatic logic [D_W-1:0] smax(input logic [D_W-1:0] a, input logic [D_W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    function automatic logic [AW-1:0] sdiff(input logic [D_W-1:0] a, input logic [D_W-1:0] b);
        return {a[D_W-1], a} - {b[D_W-1], b};
    endfunction

    // exp(x) = 2^(x*log2e); fractional power of two approximated linearly, so it stays monotonic
    function automatic logic [D_W-1:0] exp_fn(input logic [AW-1:0] x);
        logic signed [31:0] xs, y, ip;
        logic [31:0]        mant;
        xs   = {{(32 - AW){x[AW-1]}}, x};
        y    = (xs * LOG2E) >>> FRAC;
        ip   = y >>> FRAC;
        mant = {{(31 - FRAC){1'b0}}, 1'b1, y[FRAC-1:0]};
        if (xs >= 0) return ONE;
        if (xs <= EXP_FLOOR) return '0;
        return D_W'(mant >> (-ip));
    endfunction

    assign O_S_RDY   = (state_q == StIdle) || (state_q == StLoad);
    assign O_ENA     = (state_q == StOut);
    assign O_BUSY    = (state_q != StIdle);
    assign col_acc   = I_S_VLD && O_S_RDY;
    assign last_col  = col_acc && (state_q == StLoad) && (col_cnt_q == BW'(COLS - 1));
    assign rd_idx    = BW'(iss_cnt_q - CW'(1));
    assign out_vld   = e_vld_q[EXP_LAT-1];
    assign out_item0 = e_item0_q[EXP_LAT-1];
    assign out_last  = e_last_q[EXP_LAT-1];
    assign O_LI_OLD  = l_old_q;
    assign O_MI_OLD  = m_old_q;
    assign O_LI_NEW  = l_new_q;
    assign O_MI_NEW  = m_new_q;

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (col_acc) state_d = StLoad;
            StLoad:  if (last_col) state_d = StSum;
            StSum:   if (iss_cnt_q == CW'(COLS)) state_d = StDrain;
            StDrain: if (out_vld && out_last) state_d = StScale;
            StScale: state_d = StOut;
            StOut:   if (I_UPD_VLD) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // l_new = (l_old * alpha) >>> FRAC + sum, clamped to [0, L_MAX]
    always_comb begin
        for (int r = 0; r < TIL; r++) begin
            prod[r]  = $signed({{D_W{l_old_q[r][D_W-1]}}, l_old_q[r]}) *
                       $signed({{D_W{alpha_q[r][D_W-1]}}, alpha_q[r]});
            total[r] = (prod[r] >>> FRAC) + $signed({{(PW - SW){1'b0}}, sum_q[r]});
            if (total[r] > $signed({{D_W{1'b0}}, L_MAX})) l_sat[r] = L_MAX;
            else if (total[r] < 0)                        l_sat[r] = '0;
            else                                          l_sat[r] = total[r][D_W-1:0];
        end
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            first_q   <= 1'b1;
            col_cnt_q <= '0;
            iss_cnt_q <= '0;
            for (int r = 0; r < TIL; r++) begin
                l_old_q[r]   <= '0;
                m_old_q[r]   <= NEG_INF;
                l_new_q[r]   <= '0;
                m_new_q[r]   <= NEG_INF;
                run_max_q[r] <= '0;
                alpha_q[r]   <= '0;
                sum_q[r]     <= '0;
            end
        end else begin
            if (state_q == StIdle && I_START) begin
                first_q <= 1'b1;
                for (int r = 0; r < TIL; r++) begin
                    l_old_q[r] <= '0;
                    m_old_q[r] <= NEG_INF;
                end
            end
            if (col_acc) begin
                col_cnt_q <= last_col ? '0 : col_cnt_q + BW'(1);
                for (int r = 0; r < TIL; r++)
                    run_max_q[r] <= (state_q == StIdle) ? I_S_COL[r] : smax(run_max_q[r], I_S_COL[r]);
            end
            if (last_col) begin
                iss_cnt_q <= '0;
                for (int r = 0; r < TIL; r++) begin
                    m_new_q[r] <= smax(m_old_q[r], smax(run_max_q[r], I_S_COL[r]));
                    sum_q[r]   <= '0;
                end
            end
            if (state_q == StSum) iss_cnt_q <= iss_cnt_q + CW'(1);
            if (out_vld) begin
                for (int r = 0; r < TIL; r++) begin
                    if (out_item0) alpha_q[r] <= first_q ? '0 : exp_q[EXP_LAT-1][r];
                    else           sum_q[r]   <= sum_q[r] + SW'(exp_q[EXP_LAT-1][r]);
                end
            end
            if (state_q == StScale) begin
                for (int r = 0; r < TIL; r++) l_new_q[r] <= l_sat[r];
            end
            if (state_q == StOut && I_UPD_VLD) begin
                first_q <= 1'b0;
                for (int r = 0; r < TIL; r++) begin
                    l_old_q[r] <= l_new_q[r];
                    m_old_q[r] <= m_new_q[r];
                end
            end
        end
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            a_vld_q   <= 1'b0;
            a_item0_q <= 1'b0;
            a_last_q  <= 1'b0;
            e_vld_q   <= '0;
            e_item0_q <= '0;
            e_last_q  <= '0;
        end else begin
            a_vld_q      <= (state_q == StSum);
            a_item0_q    <= (iss_cnt_q == '0);
            a_last_q     <= (iss_cnt_q == CW'(COLS));
            e_vld_q[0]   <= a_vld_q;
            e_item0_q[0] <= a_item0_q;
            e_last_q[0]  <= a_last_q;
            for (int s = 1; s < EXP_LAT; s++) begin
                e_vld_q[s]   <= e_vld_q[s-1];
                e_item0_q[s] <= e_item0_q[s-1];
                e_last_q[s]  <= e_last_q[s-1];
            end
        end
    end

    // Tile buffer and exp datapath carry no reset; validity travels with the tag pipe
    always_ff @(posedge I_CLK) begin
        for (int r = 0; r < TIL; r++) begin
            if (col_acc) tile_q[col_cnt_q][r] <= I_S_COL[r];
            arg_q[r]    <= (iss_cnt_q == '0) ? sdiff(m_old_q[r], m_new_q[r])
                                             : sdiff(tile_q[rd_idx][r], m_new_q[r]);
            exp_q[0][r] <= exp_fn(arg_q[r]);
            for (int s = 1; s < EXP_LAT; s++) exp_q[s][r] <= exp_q[s-1][r];
        end
    end

endmodule
